// File: rtl/stream_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_rr_arbiter_if
// Description : Bundle for the stream_rr_arbiter. It carries the NUM_REQ
//               requester streams (data/valid/last in, ready out) and the
//               single shared output stream (data/last/grant/valid out,
//               ready in).
//               slave  : the arbiter's view.
//               master : the view of the environment that drives the
//                        requesters and sinks the output.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_rr_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int GRANT_WIDTH = 2
);

  // Requester side: requester i owns slice [i*DATA_WIDTH +: DATA_WIDTH]
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ-1:0]            in_last;
  logic [NUM_REQ-1:0]            in_ready;

  // Shared output stream
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_last;
  logic [GRANT_WIDTH-1:0]        out_grant;
  logic                          out_valid;
  logic                          out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output out_data,
    output out_last,
    output out_grant,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  out_data,
    input  out_last,
    input  out_grant,
    input  out_valid,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_rr_arbiter
// Description : Packet-granular round-robin arbiter. It merges NUM_REQ
//               valid/ready streams into one registered output stream.
//               - A grant stays locked until the winner sends a beat with
//                 last=1.
//               - The output is a one-entry pipe register, which keeps one
//                 beat per cycle.
//               Optional macro STREAM_ARB_FIXED_PRIO_EN: when defined, the
//               idle winner is the lowest-index valid requester and no
//               rotating pointer is built. Packet locking is unchanged.
//               Reset is asynchronous and active low; the port is named rst.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int GRANT_WIDTH = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  stream_rr_arbiter_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants and types
  // --------------------------------------------------------------------------
  localparam logic [GRANT_WIDTH-1:0] c_LAST_IDX = GRANT_WIDTH'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Arbitration state
  // --------------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [GRANT_WIDTH-1:0] r_lock;
  logic [GRANT_WIDTH-1:0] w_lock_nxt;

  // --------------------------------------------------------------------------
  // Output pipe register
  // --------------------------------------------------------------------------
  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_last;
  logic [GRANT_WIDTH-1:0] r_grant;

  // --------------------------------------------------------------------------
  // Combinational arbitration / handshake
  // --------------------------------------------------------------------------
  logic                   w_stage_ready;
  logic [GRANT_WIDTH-1:0] w_idle_pick;
  logic                   w_idle_found;
  logic [GRANT_WIDTH-1:0] w_win;
  logic                   w_have_win;
  logic                   w_win_valid;
  logic                   w_win_last;
  logic [DATA_WIDTH-1:0]  w_win_data;
  logic [NUM_REQ-1:0]     w_in_ready;
  logic                   w_xfer;
  logic [GRANT_WIDTH-1:0] w_win_inc;

  // The stage can take a beat when it is empty or being drained this cycle
  assign w_stage_ready = bus.out_ready | ~r_valid;

  // Index after the winner, wrapping NUM_REQ-1 back to 0
  assign w_win_inc = (w_win == c_LAST_IDX) ? '0 : (w_win + GRANT_WIDTH'(1));

`ifdef STREAM_ARB_FIXED_PRIO_EN

  // Idle pick: lowest-index valid requester has highest priority
  always_comb begin
    w_idle_pick  = '0;
    w_idle_found = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.in_valid[j]) begin
        w_idle_pick  = GRANT_WIDTH'(j);
        w_idle_found = 1'b1;
      end
    end
  end

`else

  logic [GRANT_WIDTH-1:0] r_ptr;
  logic [GRANT_WIDTH-1:0] w_ptr_nxt;
  logic [NUM_REQ-1:0]     w_masked;

  // Idle pick: round robin starting at r_ptr.
  // - First look for valid requesters at or above the pointer.
  // - If none is valid there, wrap to the lowest valid index overall.
  // - Scanning downward lets the lowest qualifying index overwrite the rest.
  always_comb begin
    w_masked     = '0;
    w_idle_pick  = '0;
    w_idle_found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_masked[j] = bus.in_valid[j] & (j >= int'(r_ptr));
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.in_valid[j]) begin
        w_idle_pick  = GRANT_WIDTH'(j);
        w_idle_found = 1'b1;
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_masked[j]) begin
        w_idle_pick = GRANT_WIDTH'(j);
      end
    end
  end

  // Pointer advances only when a packet actually completes
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_xfer && w_win_last) begin
      w_ptr_nxt = w_win_inc;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

`endif

  // Winner: the lock holder while locked, else the idle pick
  always_comb begin
    w_win      = '0;
    w_have_win = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_win      = r_lock;
      w_have_win = 1'b1;
    end else begin
      w_win      = w_idle_pick;
      w_have_win = w_idle_found;
    end
  end

  // Route the winner's beat and drive ready to the winner only.
  // Ready stays low while reset is asserted.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_last  = 1'b0;
    w_win_data  = '0;
    w_in_ready  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win == GRANT_WIDTH'(j)) begin
        w_win_valid   = bus.in_valid[j];
        w_win_last    = bus.in_last[j];
        w_win_data    = bus.in_data[j*DATA_WIDTH +: DATA_WIDTH];
        w_in_ready[j] = rst & w_have_win & w_stage_ready;
      end
    end
  end

  assign w_xfer = rst & w_have_win & w_win_valid & w_stage_ready;

  // Next state: lock on a non-final beat, release on the final beat
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && !w_win_last) begin
          w_state_nxt = ST_LOCKED;
          w_lock_nxt  = w_win;
        end
      end
      ST_LOCKED: begin
        if (w_xfer && w_win_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbitration state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  // Output pipe register.
  // - A load wins over a drain, so load+drain in one cycle stays full.
  // - The payload holds its value once drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_grant <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_win_data;
      r_last  <= w_win_last;
      r_grant <= w_win;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign bus.out_grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_rr_arbiter
// Description : Directed self-checking bench for stream_rr_arbiter.
//               Covers reset, round robin, packet lock, pointer wrap,
//               backpressure and (under STREAM_ARB_FIXED_PRIO_EN) fixed
//               priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_rr_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_WIDTH  = 8;
  localparam int GRANT_WIDTH = 2;
`ifdef STREAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  stream_rr_arbiter_if #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .GRANT_WIDTH(GRANT_WIDTH)
  ) u_if ();

  stream_rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .GRANT_WIDTH(GRANT_WIDTH)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
    u_if.in_valid[i] = v;
    u_if.in_last[i]  = l;
    u_if.in_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic check_beat(input string tag, input int g, input logic [7:0] d);
    check({tag, "_valid"}, 32'(u_if.out_valid), 32'd1);
    check({tag, "_grant"}, 32'(u_if.out_grant), 32'(g));
    check({tag, "_data"},  32'(u_if.out_data),  32'(d));
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_g;
    int          n_out;
    int          c;
    int          cnt [NUM_REQ];
    logic [7:0]  held;
    logic [3:0]  xf;
    int          bp_g [10];
    logic [7:0]  bp_d [10];

    bp_g = '{2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    bp_d = '{8'h20, 8'h30, 8'h00, 8'h10, 8'h21, 8'h31, 8'h01, 8'h11, 8'h22, 8'h32};
    held = 8'h00;

    // ---------------- Reset with all requesters valid ----------------
    rst = 1'b0;
    u_if.out_ready = 1'b1;
    idle_all();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 8'(8'hA0 + i));
    tick();
    tick();
    check("rst_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_data",  32'(u_if.out_data),  32'd0);
    check("rst_grant", 32'(u_if.out_grant), 32'd0);
    check("rst_last",  32'(u_if.out_last),  32'd0);
    check("rst_ready", 32'(u_if.in_ready),  32'd0);
    rst = 1'b1;
    #1;
    check("first_ready", 32'(u_if.in_ready), 32'h1);

    // ---------------- Round robin, single-beat packets ----------------
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_g = FIXED ? 0 : (k % 4);
      check_beat($sformatf("rr%0d", k), exp_g, 8'(8'hA0 + exp_g));
    end

    // ---------------- Asynchronous reset mid-traffic ----------------
    #2;
    rst = 1'b0;
    #1;
    check("mid_valid", 32'(u_if.out_valid), 32'd0);
    check("mid_data",  32'(u_if.out_data),  32'd0);
    check("mid_grant", 32'(u_if.out_grant), 32'd0);
    check("mid_ready", 32'(u_if.in_ready),  32'd0);
    tick();
    check("mid_ready2", 32'(u_if.in_ready),  32'd0);
    check("mid_valid2", 32'(u_if.out_valid), 32'd0);
    rst = 1'b1;
    tick();
    check_beat("post_rst", 0, 8'hA0);

    // ---------------- Packet lock ----------------
    idle_all();
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h01);
    set_req(1, 1'b1, 1'b1, 8'h11);
    set_req(2, 1'b1, 1'b1, 8'h21);
    #1;
    check("lock_ready0", 32'(u_if.in_ready), 32'h1);
    tick();
    check_beat("lock_b1", 0, 8'h01);
    check("lock_b1_last", 32'(u_if.out_last), 32'd0);
    set_req(0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("gap%0d_valid", k), 32'(u_if.out_valid), 32'd0);
      check($sformatf("gap%0d_ready", k), 32'(u_if.in_ready),  32'h1);
    end
    set_req(0, 1'b1, 1'b0, 8'h02);
    tick();
    check_beat("lock_b2", 0, 8'h02);
    set_req(0, 1'b1, 1'b1, 8'h03);
    tick();
    check_beat("lock_b3", 0, 8'h03);
    check("lock_b3_last", 32'(u_if.out_last), 32'd1);
    set_req(0, 1'b0, 1'b0, 8'h00);
    tick();
    check_beat("lock_r1", 1, 8'h11);
    set_req(1, 1'b0, 1'b0, 8'h00);
    tick();
    check_beat("lock_r2", 2, 8'h21);

`ifndef STREAM_ARB_FIXED_PRIO_EN
    // ---------------- Pointer wrap ----------------
    set_req(2, 1'b0, 1'b0, 8'h00);
    set_req(3, 1'b1, 1'b1, 8'h31);
    tick();
    check_beat("wrap_r3", 3, 8'h31);
    set_req(3, 1'b0, 1'b0, 8'h00);
    set_req(0, 1'b1, 1'b1, 8'h0A);
    set_req(1, 1'b1, 1'b1, 8'h1A);
    tick();
    check_beat("wrap_r0", 0, 8'h0A);
    tick();
    check_beat("wrap_r1", 1, 8'h1A);
    idle_all();
    tick();
    check("wrap_drain", 32'(u_if.out_valid), 32'd0);

    // ---------------- Backpressure, 10-beat sequence ----------------
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      set_req(i, 1'b1, 1'b1, 8'(i * 16));
    end
    n_out = 0;
    c     = 0;
    while (n_out < 10 && c < 60) begin
      u_if.out_ready = !(c >= 2 && c < 7);
      #1;
      if (c >= 2 && c < 7) begin
        check($sformatf("bp_ready_c%0d", c), 32'(u_if.in_ready), 32'd0);
        if (c == 2) held = u_if.out_data;
        else check($sformatf("bp_hold_c%0d", c), 32'(u_if.out_data), 32'(held));
      end
      if (u_if.out_valid && u_if.out_ready) begin
        check($sformatf("bp%0d_grant", n_out), 32'(u_if.out_grant), 32'(bp_g[n_out]));
        check($sformatf("bp%0d_data", n_out),  32'(u_if.out_data),  32'(bp_d[n_out]));
        n_out++;
      end
      xf = u_if.in_valid & u_if.in_ready;
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xf[i]) begin
          cnt[i]++;
          set_req(i, 1'b1, 1'b1, 8'(i * 16 + cnt[i]));
        end
      end
      c++;
    end
    check("bp_count", 32'(n_out), 32'd10);
    u_if.out_ready = 1'b1;
    idle_all();
`else
    // ---------------- Fixed priority ----------------
    idle_all();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 8'(8'hA0 + i));
    for (int k = 0; k < 3; k++) begin
      tick();
      check_beat($sformatf("fp%0d", k), 0, 8'hA0);
    end
    set_req(0, 1'b0, 1'b0, 8'h00);
    tick();
    check_beat("fp_r1", 1, 8'hA1);
    idle_all();
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
